// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: port width, register offsets and
// the register-select enum decoded from bus_addr[4:2].
package gpio_ctrl_pkg;

  localparam int unsigned GPIO_W = 8;

  localparam logic [2:0] GPIO_OUT       = 3'd0;
  localparam logic [2:0] GPIO_IN        = 3'd1;
  localparam logic [2:0] GPIO_IRQ_EN    = 3'd2;
  localparam logic [2:0] GPIO_EDGE_RISE = 3'd3;
  localparam logic [2:0] GPIO_EDGE_BOTH = 3'd4;
  localparam logic [2:0] GPIO_IRQ_PEND  = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET   = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR   = 3'd7;

  typedef enum logic [2:0] {
    SelOut      = GPIO_OUT,
    SelIn       = GPIO_IN,
    SelIrqEn    = GPIO_IRQ_EN,
    SelEdgeRise = GPIO_EDGE_RISE,
    SelEdgeBoth = GPIO_EDGE_BOTH,
    SelIrqPend  = GPIO_IRQ_PEND,
    SelOutSet   = GPIO_OUT_SET,
    SelOutClr   = GPIO_OUT_CLR
  } gpio_reg_sel_t;

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin two-flop synchroniser, stability counter and edge detector.
// o_rise/o_fall pulse in the cycle whose closing edge updates o_stable.
module gpio_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic [CntW-1:0] r_cnt;
  logic            w_update;

  assign w_update = (r_sync2 != r_stable) && (r_cnt == CntMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_update & r_sync2;
  assign o_fall   = w_update & ~r_sync2;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: output register with atomic set/clear, debounced
// inputs, per-pin edge capture into W1C pending bits and a level interrupt.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [GPIO_W-1:0] i_gpio_port_in,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic              i_bus_wren,
  input  logic              i_bus_rden,
  input  logic [31:0]       i_bus_wrdata,
  output logic [31:0]       o_bus_rddata,
  output logic [GPIO_W-1:0] o_gpio_port_out,
  output logic              o_irq
);

  logic [GPIO_W-1:0] r_out, r_irq_en, r_edge_rise, r_edge_both, r_irq_pend;
  logic [31:0]       r_rddata;

  logic [GPIO_W-1:0] w_in, w_rise, w_fall, w_hit, w_wd, w_w1c;
  logic [GPIO_W-1:0] w_out_nxt, w_irq_en_nxt, w_edge_rise_nxt, w_edge_both_nxt, w_pend_nxt;
  logic [31:0]       w_rd_val;
  gpio_reg_sel_t     w_sel;
  logic              w_unused;

  assign w_sel    = gpio_reg_sel_t'(i_bus_addr[4:2]);
  assign w_wd     = i_bus_wrdata[GPIO_W-1:0];
  assign w_unused = ^{i_bus_addr[1:0], i_bus_wrdata[31:GPIO_W]};

  for (genvar g = 0; g < GPIO_W; g++) begin : g_pin
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_pin   (i_gpio_port_in[g]),
      .o_stable(w_in[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  // EDGE_BOTH overrides the rise/fall selection.
  assign w_hit = (r_edge_both & (w_rise | w_fall)) |
                 (r_edge_rise & w_rise) | (~r_edge_rise & w_fall);

  always_comb begin
    w_out_nxt       = r_out;
    w_irq_en_nxt    = r_irq_en;
    w_edge_rise_nxt = r_edge_rise;
    w_edge_both_nxt = r_edge_both;
    w_w1c           = '0;
    if (i_bus_wren) begin
      unique case (w_sel)
        SelOut:      w_out_nxt       = w_wd;
        SelIrqEn:    w_irq_en_nxt    = w_wd;
        SelEdgeRise: w_edge_rise_nxt = w_wd;
        SelEdgeBoth: w_edge_both_nxt = w_wd;
        SelIrqPend:  w_w1c           = w_wd;
        SelOutSet:   w_out_nxt       = r_out | w_wd;
        SelOutClr:   w_out_nxt       = r_out & ~w_wd;
        default:     ;
      endcase
    end
    // A new edge in the same cycle as a clear keeps the bit set.
    w_pend_nxt = (r_irq_pend & ~w_w1c) | w_hit;
  end

  always_comb begin
    w_rd_val = '0;
    unique case (w_sel)
      SelOut:      w_rd_val[GPIO_W-1:0] = r_out;
      SelIn:       w_rd_val[GPIO_W-1:0] = w_in;
      SelIrqEn:    w_rd_val[GPIO_W-1:0] = r_irq_en;
      SelEdgeRise: w_rd_val[GPIO_W-1:0] = r_edge_rise;
      SelEdgeBoth: w_rd_val[GPIO_W-1:0] = r_edge_both;
      SelIrqPend:  w_rd_val[GPIO_W-1:0] = r_irq_pend;
      default:     w_rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out       <= '0;
      r_irq_en    <= '0;
      r_edge_rise <= '0;
      r_edge_both <= '0;
      r_irq_pend  <= '0;
      r_rddata    <= '0;
    end else begin
      r_out       <= w_out_nxt;
      r_irq_en    <= w_irq_en_nxt;
      r_edge_rise <= w_edge_rise_nxt;
      r_edge_both <= w_edge_both_nxt;
      r_irq_pend  <= w_pend_nxt;
      if (i_bus_rden) r_rddata <= w_rd_val;
    end
  end

  assign o_bus_rddata    = r_rddata;
  assign o_gpio_port_out = r_out;
  assign o_irq           = |(r_irq_pend & r_irq_en);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: reads are scored through an expected-value queue,
// pin/irq levels are checked directly. Inputs change and outputs are sampled on negedge.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pins;
  logic [4:0]  addr;
  logic        wren, rden;
  logic [31:0] wrdata;
  logic [31:0] rddata;
  logic [7:0]  gpio_out;
  logic        irq;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] sb_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  gpio_ctrl #(
    .DB_CYCLES(4),
    .ADDR_W   (5)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_gpio_port_in (pins),
    .i_bus_addr     (addr),
    .i_bus_wren     (wren),
    .i_bus_rden     (rden),
    .i_bus_wrdata   (wrdata),
    .o_bus_rddata   (rddata),
    .o_gpio_port_out(gpio_out),
    .o_irq          (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] sel, input logic [7:0] d);
    addr   = {sel, 2'b00};
    wrdata = {24'hC0FFEE, d};
    wren   = 1'b1;
    @(negedge clk);
    wren   = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] sel, input logic [7:0] exp, input string tag);
    addr = {sel, 2'b00};
    rden = 1'b1;
    sb_q.push_back({24'h0, exp});
    tag_q.push_back(tag);
    @(negedge clk);
    rden = 1'b0;
    check(tag_q.pop_front(), rddata, sb_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all pins high
    rst_n = 1'b0; pins = 8'hFF; addr = '0; wren = 1'b0; rden = 1'b0; wrdata = '0;
    tick(3);
    check("rst_out", {24'h0, gpio_out}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rddata", rddata, 32'h0);
    rst_n = 1'b1;
    tick(5);
    bus_rd(GPIO_IN, 8'h00, "in_edge6_pre");
    bus_rd(GPIO_IN, 8'hFF, "in_edge7");
    bus_rd(GPIO_IRQ_PEND, 8'h00, "pend_after_rise");

    // Falling edges are selected after reset
    pins = 8'h00;
    tick(8);
    bus_rd(GPIO_IN, 8'h00, "in_all_low");
    bus_rd(GPIO_IRQ_PEND, 8'hFF, "pend_all_fell");
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus_wr(GPIO_IRQ_PEND, 8'hFF);
    bus_rd(GPIO_IRQ_PEND, 8'h00, "pend_w1c_all");

    // Output register, set and clear
    bus_wr(GPIO_OUT, 8'hA5);
    check("out_write", {24'h0, gpio_out}, 32'hA5);
    bus_wr(GPIO_OUT_SET, 8'h0A);
    check("out_set", {24'h0, gpio_out}, 32'hAF);
    bus_wr(GPIO_OUT_CLR, 8'h81);
    check("out_clr", {24'h0, gpio_out}, 32'h2E);
    bus_rd(GPIO_OUT, 8'h2E, "rd_out");
    bus_rd(GPIO_OUT_SET, 8'h00, "rd_out_set");
    bus_rd(GPIO_OUT_CLR, 8'h00, "rd_out_clr");
    bus_wr(GPIO_IN, 8'hFF);
    bus_rd(GPIO_IN, 8'h00, "in_write_ignored");

    // Read and write together: old value returned, write applied
    addr = {GPIO_OUT, 2'b00}; wrdata = 32'h0000005A; wren = 1'b1; rden = 1'b1;
    sb_q.push_back(32'h2E); tag_q.push_back("rdwr_old");
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
    check(tag_q.pop_front(), rddata, sb_q.pop_front());
    check("rdwr_new", {24'h0, gpio_out}, 32'h5A);

    // Glitch on pin 3 is filtered; long pulse passes
    bus_wr(GPIO_EDGE_BOTH, 8'h08);
    pins = 8'h08; tick(3); pins = 8'h00;
    tick(10);
    bus_rd(GPIO_IN, 8'h00, "glitch_in");
    bus_rd(GPIO_IRQ_PEND, 8'h00, "glitch_pend");
    pins = 8'h08;
    tick(5);
    bus_rd(GPIO_IN, 8'h00, "pulse_edge6_pre");
    bus_rd(GPIO_IN, 8'h08, "pulse_edge7");
    tick(3);
    pins = 8'h00;
    tick(10);
    bus_rd(GPIO_IN, 8'h00, "pulse_fall_in");
    bus_rd(GPIO_IRQ_PEND, 8'h08, "pulse_both_pend");
    bus_wr(GPIO_IRQ_PEND, 8'h08);
    bus_wr(GPIO_EDGE_BOTH, 8'h00);

    // Edge selection and interrupt
    pins = 8'h02;
    tick(8);
    bus_wr(GPIO_EDGE_RISE, 8'h01);
    bus_wr(GPIO_EDGE_BOTH, 8'h02);
    bus_wr(GPIO_IRQ_EN, 8'h03);
    check("irq_idle", {31'h0, irq}, 32'h0);
    bus_rd(GPIO_IRQ_PEND, 8'h00, "pend_cfg");
    pins = 8'h03;
    tick(8);
    bus_rd(GPIO_IRQ_PEND, 8'h01, "rise_pin0");
    check("irq_rise_pin0", {31'h0, irq}, 32'h1);
    pins = 8'h02;
    tick(8);
    bus_rd(GPIO_IRQ_PEND, 8'h01, "fall_pin0_nohit");
    pins = 8'h00;
    tick(8);
    bus_rd(GPIO_IRQ_PEND, 8'h03, "fall_pin1_both");
    bus_wr(GPIO_IRQ_EN, 8'h00);
    check("irq_en_mask", {31'h0, irq}, 32'h0);
    bus_rd(GPIO_IRQ_PEND, 8'h03, "pend_kept_masked");
    bus_wr(GPIO_IRQ_EN, 8'h03);
    check("irq_unmask", {31'h0, irq}, 32'h1);

    // Set wins over W1C on the same edge
    bus_wr(GPIO_IRQ_PEND, 8'h02);
    bus_rd(GPIO_IRQ_PEND, 8'h01, "w1c_pin1");
    pins = 8'h01;
    tick(5);
    bus_wr(GPIO_IRQ_PEND, 8'h01);
    bus_rd(GPIO_IRQ_PEND, 8'h01, "set_wins");
    bus_rd(GPIO_IN, 8'h01, "in_pin0_high");
    bus_wr(GPIO_IRQ_PEND, 8'h01);
    bus_rd(GPIO_IRQ_PEND, 8'h00, "w1c_pin0");
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // Asynchronous reset in the middle of a debounce on pin 5
    bus_rd(GPIO_OUT, 8'h5A, "out_before_rst");
    pins = 8'h21;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("arst_out", {24'h0, gpio_out}, 32'h0);
    check("arst_rddata", rddata, 32'h0);
    check("arst_irq", {31'h0, irq}, 32'h0);
    #2;
    rst_n = 1'b1;
    tick(5);
    bus_rd(GPIO_IN, 8'h00, "arst_in_edge6_pre");
    bus_rd(GPIO_IN, 8'h21, "arst_in_edge7");
    bus_rd(GPIO_IRQ_PEND, 8'h00, "arst_pend");
    bus_rd(GPIO_IRQ_EN, 8'h00, "arst_irq_en");
    bus_rd(GPIO_EDGE_RISE, 8'h00, "arst_edge_rise");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Memory-mapped controller that owns the 8-bit GPIO port on the peripheral bus of the single-cycle RV32I core. It provides an output register with atomic set and clear, and synchronises and debounces the input pins. It also detects per-pin edges into a write-1-to-clear pending register and drives one level interrupt line toward the core. It sits between the data-memory address decoder and the board pins.

Parameters:
DB_CYCLES, 4, consecutive stable cycles required before a debounced input changes; legal range 1..255.
ADDR_W, 5, width of the byte offset bus_addr; register select uses bus_addr[4:2].

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
gpio_port_in  input  8  raw asynchronous input pins.
bus_addr  input  ADDR_W  byte offset within the GPIO window.
bus_wren  input  1  write strobe for the current cycle.
bus_rden  input  1  read strobe for the current cycle.
bus_wrdata  input  32  write data (RV32I_OPERAND_t).
bus_rddata  output  32  registered read data (RV32I_OPERAND_t).
gpio_port_out  output  8  output pin drive.
irq  output  1  level interrupt, high while any enabled pending bit is set.

Behaviour:
- Reset (rst=0, asynchronous) clears all state to 0: OUT, IRQ_EN, EDGE_RISE, EDGE_BOTH, IRQ_PEND, sync flops, debounced IN, counters and bus_rddata. So gpio_port_out=0 and irq=0. Reset asserted mid-debounce discards the count.
- Register map (bus_addr[4:2]). Only bits [7:0] are used; upper read bits are 0.
  - 0 OUT: RW.
  - 1 IN: RO, debounced.
  - 2 IRQ_EN: RW.
  - 3 EDGE_RISE: RW. 1 selects rising edge, 0 selects falling edge.
  - 4 EDGE_BOTH: RW. 1 selects both edges and overrides EDGE_RISE.
  - 5 IRQ_PEND: R/W1C.
  - 6 OUT_SET: WO. OUT |= wrdata.
  - 7 OUT_CLR: WO. OUT &= ~wrdata.
- Write/read rules:
  - Writes to IN are ignored.
  - Reads of OUT_SET and OUT_CLR return 0.
  - Writes take effect at the sampling edge. gpio_port_out follows OUT directly, one edge after the write.
- Read latency: 1 cycle.
  - When bus_rden=1 at an edge, bus_rddata loads the selected register's pre-edge value.
  - When bus_rden=0, bus_rddata holds its value.
  - bus_rden and bus_wren both high at the same address: the read returns the old value and the write is applied.
- Input path, per pin:
  - Two-flop synchroniser (sync1 then sync2).
  - Debounce counter cnt, width $clog2(DB_CYCLES+1):
    - If sync2==IN: cnt<=0.
    - Else if cnt==DB_CYCLES-1: IN<=sync2 and cnt<=0.
    - Else: cnt<=cnt+1.
  - A pin change that stays stable reaches IN DB_CYCLES+2 edges after it is first sampled by sync1.
  - A glitch shorter than DB_CYCLES cycles at sync2 never reaches IN.
- Edge detect, at the edge where IN[i] updates:
  - rise = new value 1, fall = new value 0.
  - hit[i] = EDGE_BOTH[i] | (EDGE_RISE[i] ? rise : fall).
  - hit sets IRQ_PEND[i] regardless of IRQ_EN, so software can poll.
- IRQ_PEND update: PEND <= (PEND & ~w1c_mask) | hit.
  - w1c_mask = bus_wrdata[7:0] when writing offset 5, else 0.
  - Set wins over clear in the same cycle.
- irq = |(IRQ_PEND & IRQ_EN), combinational from registers with no extra latency. Clearing IRQ_EN masks irq without touching PEND.
- OUT_SET and OUT_CLR are exclusive by address, so they cannot collide. A plain OUT write fully replaces OUT.

Decomposition:
- Add to fe_pkg or mem_pkg:
  - GPIO register offset localparams (GPIO_OUT=0 through GPIO_OUT_CLR=7).
  - gpio_reg_sel_t enum.
  - GPIO_W=8.
- Use the existing `FF_D_RST`/`FF_D_RST_EN` style macros for the register flops.
- One sub-module: gpio_debounce. It is a per-pin synchroniser, counter and edge detector with parameter DB_CYCLES, generated 8 times. Outputs: stable, rise, fall.

Test Plan:
1. Reset with pins=0xFF and DB_CYCLES=4. Hold rst=0 for 3 cycles -> gpio_port_out=0, irq=0, bus_rddata=0. After release, read IN at cycle 7 -> 0xFF.
2. Write OUT=0xA5, then OUT_SET=0x0A, then OUT_CLR=0x81 -> gpio_port_out goes 0xA5, 0xAF, 0x2E on consecutive edges. Reading OUT returns 0x2E one cycle after the read strobe.
3. Pin 3 pulses high for 3 cycles with DB_CYCLES=4 -> IN stays 0x00 and IRQ_PEND stays 0. A 10-cycle pulse -> IN[3]=1 exactly 6 edges after the rise; IN[3]=0 after the fall.
4. EDGE_RISE=0x01, EDGE_BOTH=0x02, IRQ_EN=0x03. Rise pin0 -> PEND=0x01, irq=1. Fall pin0 -> no new bit. Fall pin1 -> PEND=0x03.
5. Write IRQ_PEND=0x01 on the same edge pin0 debounces high -> PEND bit0 stays 1 (set wins). Next W1C of 0x01 -> bit0 clears and irq drops to 0 when no other enabled bit is pending.
6. Assert rst mid-debounce, with cnt=2 on pin 5 -> all registers are 0 immediately, without waiting for a clock edge. After release, the pin needs a full DB_CYCLES+2 edges to appear in IN.
